mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Bus bridge between the ARC datapath memory port and the peripheral block (UART + debounced strobes). Decodes the memory-mapped I/O window, converts a CPU load/store request into the long, debounce-compatible `rd`/`wr` level pulses plus `s_io`/`s_mmio` selects the peripheral block expects, captures the returned byte, and acknowledges the CPU. It sits directly upstream of the peripheral block and stalls the datapath until the access is complete.

## Interface
- `MMIO_BASE`, 32'hFFFF_FF00, base of the 256-byte I/O window (bits [31:8] compared)
- `HOLD_CYCLES`, 2_000_000, cycles `per_rd`/`per_wr` held high (must exceed debounce settle time; ≥1)
- `RELEASE_CYCLES`, 2_000_000, cycles strobes held low before ack (≥1)
- `clk` in 1 system clock, all logic on rising edge
- `rst` in 1 reset, asynchronous, active-low
- `cpu_addr` in 32 byte address of request
- `cpu_wdata` in 8 store data
- `cpu_rd` in 1 load request level, held until `cpu_ack`
- `cpu_wr` in 1 store request level, held until `cpu_ack`
- `mmio_hit` out 1 combinational: `cpu_addr[31:8] == MMIO_BASE[31:8]`
- `cpu_busy` out 1 high in every state except IDLE
- `cpu_ack` out 1 one-cycle completion pulse
- `cpu_rdata` out 8 load result, registered, valid from `cpu_ack` until next accept
- `per_rd`, `per_wr` out 1 each strobe levels to peripheral block
- `per_s_mmio` out 1 peripheral selected
- `per_s_io` out 1 1 = UART data register, 0 = status register
- `per_data_in` out 8 byte to UART TX FIFO
- `per_data_out` in 8 byte from peripheral mux (data or `{6'b0, tx_full, rx_empty}`)

## Operation
- Register map (offset = `cpu_addr[7:0]`): 0x00 DATA (R pops RX FIFO, W pushes TX FIFO); 0x04 STATUS (R only; W ignored); others unmapped.
- Arming: a request is accepted only in IDLE, with `mmio_hit`=1, and only if `armed`=1. `armed` clears on `cpu_ack`, sets on any cycle with `cpu_rd`=`cpu_wr`=0; reset value 1. Prevents a held request retriggering.
- `cpu_rd` and `cpu_wr` both high: treated as write.
- States: IDLE, SETUP, ASSERT, RELEASE, ACK.
- IDLE → SETUP on accept; latch offset, op, `cpu_wdata`.
- SETUP (1 cycle): `per_s_mmio`=1, `per_s_io`=(offset==0x00), strobes 0; at end of cycle capture `per_data_out` into `cpu_rdata` for reads (DATA byte captured before pop); unmapped read loads 0x00. Next: ASSERT for DATA read/write; ACK for STATUS read, STATUS write, unmapped access (no strobe ever).
- ASSERT: `per_rd` or `per_wr` = 1 for exactly HOLD_CYCLES; `per_data_in` = latched wdata; selects held.
- RELEASE: strobes 0, selects and `per_data_in` held, RELEASE_CYCLES cycles.
- ACK: `cpu_ack`=1 one cycle, selects dropped → IDLE.
- Single down-counter, width ceil(log2(max(HOLD,RELEASE)+1)); loaded on entry, state exits when it reaches 1; no wrap.
- `per_s_mmio`, `per_s_io`, strobes are registered outputs (glitch-free into debounce logic).
- Bridge does not poll TX-full/RX-empty; software reads STATUS first.

## Timing
- Reset (async, any state): state IDLE, all outputs except `mmio_hit` = 0, `cpu_rdata`=0x00, counter 0, `armed`=1; strobes fall immediately, in-flight access abandoned, no ack.
- Accept at edge k: SETUP cycle k+1; DATA access: ASSERT k+2..k+1+H, RELEASE k+2+H..k+1+H+R, `cpu_ack` at k+2+H+R. STATUS/unmapped: `cpu_ack` at k+2.
- `cpu_busy` rises the cycle after accept, falls with return to IDLE (cycle after ack).
- Request deasserted mid-access: ignored; access completes and acks.
- Back-to-back: next request accepted no earlier than 2 cycles after ack (drop + IDLE).

## Test plan
- H=8, R=6: store 0x41 to 0xFFFF_FF00 → `per_wr` high exactly 8 cycles, `per_data_in`=0x41, `per_s_io`=1, `cpu_ack` 16 cycles after accept, single pulse.
- `per_data_out`=0x5A, load from 0xFFFF_FF00 → `cpu_rdata`=0x5A at ack though `per_data_out` changes to 0x00 during ASSERT; `per_rd` high 8 cycles.
- `per_data_out`=0x02, load 0xFFFF_FF04 → `per_s_io`=0, no strobe, ack 2 cycles after accept, `cpu_rdata`=0x02; store to 0x04 and load 0x10 → no strobe, load returns 0x00.
- Load 0x0000_1000 → `mmio_hit`=0, `cpu_busy` stays 0, no ack; `cpu_rd` held 5 cycles past ack → exactly one access.
- `cpu_rd`=`cpu_wr`=1 at 0x00 → `per_wr` only.
- `rst` low in 4th ASSERT cycle → `per_wr`, `per_s_mmio`, `cpu_busy` 0 before next edge, no ack; after release new store completes normally.

Source files
------------

// File: rtl/mmio_bridge_if.sv
// CPU-side memory port of the MMIO bridge: request (address, store data,
// load/store levels) from the datapath, and decode/stall/ack/read data back.
`timescale 1ns/1ps

interface mmio_bridge_if;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        mmio_hit;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    // Datapath side: issues requests, observes stall/ack/data.
    modport master (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        input  mmio_hit, cpu_busy, cpu_ack, cpu_rdata
    );

    // Bridge side: decodes requests and answers them.
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        output mmio_hit, cpu_busy, cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/mmio_bridge.sv
// MMIO bridge: decodes the 256-byte I/O window and turns one CPU load/store
// into long, debounce-friendly rd/wr strobe levels with registered selects,
// captures the returned byte and acknowledges the CPU with a one-cycle pulse.
`timescale 1ns/1ps

module mmio_bridge #(
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF_FF00,
    parameter int unsigned HOLD_CYCLES    = 2_000_000,
    parameter int unsigned RELEASE_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    mmio_bridge_if.slave      cpu,
    output logic              per_rd,
    output logic              per_wr,
    output logic              per_s_mmio,
    output logic              per_s_io,
    output logic [7:0]        per_data_in,
    input  logic [7:0]        per_data_out
);

    localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ASSERT,
        S_RELEASE,
        S_ACK
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               armed;
    logic [7:0]         off_q;
    logic               wr_q;
    logic [7:0]         wdata_q;
    logic               ack_q;
    logic [7:0]         rdata_q;

    logic               accept;
    logic               cnt_done;
    logic               is_data;
    logic               is_mapped;
    logic [7:0]         off_next;
    logic               in_access;

    assign cpu.mmio_hit  = (cpu.cpu_addr[31:8] == MMIO_BASE[31:8]);
    assign cpu.cpu_busy  = (state != S_IDLE);
    assign cpu.cpu_ack   = ack_q;
    assign cpu.cpu_rdata = rdata_q;

    assign accept    = (state == S_IDLE) && cpu.mmio_hit && armed && (cpu.cpu_rd || cpu.cpu_wr);
    assign cnt_done  = (cnt == CNT_W'(1));
    assign is_data   = (off_q == OFF_DATA);
    assign is_mapped = is_data || (off_q == OFF_STATUS);
    // Offset of the access about to be in flight: fresh on accept, latched otherwise.
    assign off_next  = accept ? cpu.cpu_addr[7:0] : off_q;
    assign in_access = (next_state == S_SETUP) || (next_state == S_ASSERT) || (next_state == S_RELEASE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Next-state decode; only DATA accesses ever drive a strobe.
    // NOTE: next_state gets its default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (accept)   next_state = S_SETUP;
            S_SETUP:   next_state = is_data ? S_ASSERT : S_ACK;
            S_ASSERT:  if (cnt_done) next_state = S_RELEASE;
            S_RELEASE: if (cnt_done) next_state = S_ACK;
            S_ACK:     next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Latch offset, direction and store data at accept; rd+wr together counts as a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_q   <= 8'h00;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
        end else if (accept) begin
            off_q   <= cpu.cpu_addr[7:0];
            wr_q    <= cpu.cpu_wr;
            wdata_q <= cpu.cpu_wdata;
        end
    end

    // Arming: cleared by the ack, re-set only once the CPU has dropped its request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             armed <= 1'b1;
        else if (ack_q)                       armed <= 1'b0;
        else if (!cpu.cpu_rd && !cpu.cpu_wr)  armed <= 1'b1;
    end

    // Shared phase counter: loaded on entry to ASSERT/RELEASE, counts down to 1, idle at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            case (next_state)
                S_ASSERT:  cnt <= (state != S_ASSERT)  ? CNT_W'(HOLD_CYCLES)    : cnt - CNT_W'(1);
                S_RELEASE: cnt <= (state != S_RELEASE) ? CNT_W'(RELEASE_CYCLES) : cnt - CNT_W'(1);
                default:   cnt <= '0;
            endcase
        end
    end

    // Registered peripheral selects/strobes and CPU ack, decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_s_mmio  <= 1'b0;
            per_s_io    <= 1'b0;
            per_rd      <= 1'b0;
            per_wr      <= 1'b0;
            per_data_in <= 8'h00;
            ack_q       <= 1'b0;
        end else begin
            per_s_mmio  <= in_access;
            per_s_io    <= in_access && (off_next == OFF_DATA);
            per_rd      <= (next_state == S_ASSERT) && !wr_q;
            per_wr      <= (next_state == S_ASSERT) && wr_q;
            per_data_in <= ((next_state == S_ASSERT) || (next_state == S_RELEASE)) ? wdata_q : 8'h00;
            ack_q       <= (next_state == S_ACK);
        end
    end

    // Capture read data at the end of SETUP, before the DATA strobe pops the RX FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        rdata_q <= 8'h00;
        else if (state == S_SETUP && !wr_q) rdata_q <= is_mapped ? per_data_out : 8'h00;
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge with short hold/release phases.
// Each access pushes its expected outcome to a scoreboard; a negedge monitor
// measures strobes/latency and pops/compares the record when cpu_ack fires.
`timescale 1ns/1ps

module tb_mmio_bridge;

    localparam int H = 8;
    localparam int R = 6;

    typedef struct {
        logic [7:0] rdata;
        bit         chk_rdata;
        int         lat;
        int         rd_n;
        int         wr_n;
        logic       s_io;
        logic [7:0] din;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       per_rd, per_wr, per_s_mmio, per_s_io;
    logic [7:0] per_data_in;
    logic [7:0] per_data_out = 8'h00;

    int n_checks = 0;
    int n_err    = 0;
    int n_acks   = 0;

    exp_t sb[$];

    mmio_bridge_if bus ();

    mmio_bridge #(
        .MMIO_BASE      (32'hFFFF_FF00),
        .HOLD_CYCLES    (H),
        .RELEASE_CYCLES (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (bus.slave),
        .per_rd       (per_rd),
        .per_wr       (per_wr),
        .per_s_mmio   (per_s_mmio),
        .per_s_io     (per_s_io),
        .per_data_in  (per_data_in),
        .per_data_out (per_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] rdata, input bit chk_rdata, input int lat,
                                input int rd_n, input int wr_n, input logic s_io, input logic [7:0] din);
        exp_t e;
        e.rdata = rdata; e.chk_rdata = chk_rdata; e.lat = lat;
        e.rd_n = rd_n; e.wr_n = wr_n; e.s_io = s_io; e.din = din;
        return e;
    endfunction

    // Peripheral model: a DATA read pops the RX FIFO, so its output byte changes.
    always @(posedge per_rd) per_data_out = 8'h00;

    // Monitor: per-access measurements, scoreboard pop at ack.
    int         m_lat, m_rd, m_wr;
    logic       m_sio;
    logic [7:0] m_din;
    logic       busy_q = 1'b0;
    logic       ack_q  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.cpu_busy && !busy_q) begin
            m_lat = 0; m_rd = 0; m_wr = 0; m_sio = 1'b0; m_din = 8'h00;
        end
        if (bus.cpu_busy) m_lat++;
        if (per_rd) m_rd++;
        if (per_wr) begin
            m_wr++;
            m_din = per_data_in;
        end
        if (per_s_mmio) m_sio = per_s_io;
        if (ack_q) check("ack_single_pulse", {31'd0, bus.cpu_ack}, 32'd0);
        if (bus.cpu_ack) begin
            n_acks++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_latency", m_lat, e.lat);
                check("rd_strobe_cycles", m_rd, e.rd_n);
                check("wr_strobe_cycles", m_wr, e.wr_n);
                check("s_io", {31'd0, m_sio}, {31'd0, e.s_io});
                if (e.wr_n > 0)  check("per_data_in", {24'd0, m_din}, {24'd0, e.din});
                if (e.chk_rdata) check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, e.rdata});
            end
        end
        busy_q = bus.cpu_busy;
        ack_q  = bus.cpu_ack;
    end

    // One CPU access: push expectation, drive request, wait (bounded) for ack,
    // optionally keep the request held for extra cycles, then drop it.
    task automatic access(input logic [31:0] addr, input logic [7:0] wdata, input logic rd,
                          input logic wr, input logic [7:0] pdo, input int hold, input exp_t e);
        bit got = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        per_data_out  = pdo;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        #1 check("mmio_hit_in_window", {31'd0, bus.mmio_hit}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held_req_busy", {31'd0, bus.cpu_busy}, 32'd0);
        end
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int acks_before;
        bit seen;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 8'h00;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, bus.cpu_busy}, 32'd0);
        check("rst_per_wr", {31'd0, per_wr}, 32'd0);
        check("rst_s_mmio", {31'd0, per_s_mmio}, 32'd0);
        check("rst_rdata",  {24'd0, bus.cpu_rdata}, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // DATA store, DATA load (FIFO pops mid-access), STATUS load/store, unmapped load.
        access(32'hFFFF_FF00, 8'h41, 1'b0, 1'b1, 8'h00, 0, mk(8'h00, 1'b0, 2+H+R, 0, H, 1'b1, 8'h41));
        access(32'hFFFF_FF00, 8'h00, 1'b1, 1'b0, 8'h5A, 0, mk(8'h5A, 1'b1, 2+H+R, H, 0, 1'b1, 8'h00));
        access(32'hFFFF_FF04, 8'h00, 1'b1, 1'b0, 8'h02, 0, mk(8'h02, 1'b1, 2, 0, 0, 1'b0, 8'h00));
        access(32'hFFFF_FF04, 8'hC3, 1'b0, 1'b1, 8'h02, 0, mk(8'h00, 1'b0, 2, 0, 0, 1'b0, 8'h00));
        access(32'hFFFF_FF10, 8'h00, 1'b1, 1'b0, 8'h77, 0, mk(8'h00, 1'b1, 2, 0, 0, 1'b0, 8'h00));

        // Outside the window: no decode, no stall, no ack.
        acks_before = n_acks;
        @(posedge clk); #1;
        bus.cpu_addr = 32'h0000_1000;
        bus.cpu_rd   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("miss_hit",  {31'd0, bus.mmio_hit}, 32'd0);
            check("miss_busy", {31'd0, bus.cpu_busy}, 32'd0);
        end
        check("miss_no_ack", n_acks, acks_before);
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0;
        repeat (2) @(posedge clk);

        // Held load: exactly one access even with rd held 5 cycles past ack.
        access(32'hFFFF_FF04, 8'h00, 1'b1, 1'b0, 8'h01, 5, mk(8'h01, 1'b1, 2, 0, 0, 1'b0, 8'h00));

        // rd and wr together behave as a store.
        access(32'hFFFF_FF00, 8'h33, 1'b1, 1'b1, 8'h00, 0, mk(8'h01, 1'b1, 2+H+R, 0, H, 1'b1, 8'h33));

        // Reset in the 4th ASSERT cycle abandons the store without an ack.
        acks_before = n_acks;
        @(posedge clk); #1;
        bus.cpu_addr  = 32'hFFFF_FF00;
        bus.cpu_wdata = 8'hAA;
        bus.cpu_wr    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (per_wr) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_strobe_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_per_wr", {31'd0, per_wr}, 32'd0);
        check("abort_s_mmio", {31'd0, per_s_mmio}, 32'd0);
        check("abort_busy",   {31'd0, bus.cpu_busy}, 32'd0);
        check("abort_rdata",  {24'd0, bus.cpu_rdata}, 32'd0);
        bus.cpu_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_ack", n_acks, acks_before);

        access(32'hFFFF_FF00, 8'h99, 1'b0, 1'b1, 8'h00, 0, mk(8'h00, 1'b0, 2+H+R, 0, H, 1'b1, 8'h99));

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
